// File: rtl/joust2_nv_pkg.sv
// ============================================================================
// Module   : joust2_nv_pkg
// Brief    : Shared types and constants for the NVRAM upload path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package joust2_nv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_LAT  = 2'd2,
      ST_RESP = 2'd3
   } nv_state_e;

   localparam logic [7:0] PAD_BYTE = 8'hFF;

   // Williams 2 CMOS: 1K x 4
   localparam int NV_ADDR_W = 10;
   localparam int NV_DEPTH  = 1 << NV_ADDR_W;

endpackage

`default_nettype wire

// File: rtl/nv_csum_acc.sv
// ============================================================================
// Module   : nv_csum_acc
// Brief    : 8-bit modulo-256 byte accumulator with session clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nv_csum_acc (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       clr_i,
   input  logic       add_i,
   input  logic [7:0] byte_i,
   output logic [7:0] sum_o
);

   logic [7:0] sum_q;
   logic [7:0] sum_d;

   // A clear on the session edge wins over an add in the same cycle
   always_comb begin
      sum_d = sum_q;
      if (clr_i) begin
         sum_d = 8'h00;
      end else if (add_i) begin
         sum_d = sum_q + byte_i;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sum_q <= 8'h00;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

`default_nettype wire

// File: rtl/nvram_upload_ctrl.sv
// ============================================================================
// Module   : nvram_upload_ctrl
// Brief    : Serves CMOS bytes to the HPS ioctl upload path, tracks dirty state.
//            Optional macro NVRAM_UPLOAD_CSUM_EN adds a checksum byte at DEPTH.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nvram_upload_ctrl
   import joust2_nv_pkg::*;
#(
   parameter int ADDR_W      = NV_ADDR_W,
   parameter int DATA_W      = 4,
   parameter int RD_LAT      = 1,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_upload,
   input  logic              ioctl_rd,
   input  logic [24:0]       ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_wait,
   output logic              nv_req,
   output logic [ADDR_W-1:0] nv_addr,
   input  logic              nv_gnt,
   input  logic [DATA_W-1:0] nv_q,
   input  logic              cpu_nv_we,
   output logic              nv_dirty,
   output logic              upload_busy,
   output logic              upload_done
);

   localparam int               DEPTH    = 1 << ADDR_W;
   localparam int               CNT_W    = $clog2(TIMEOUT_CYC + RD_LAT + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

   nv_state_e         state_q;
   logic              upload_q;
   logic [7:0]        din_q;
   logic              wait_q;
   logic              req_q;
   logic [ADDR_W-1:0] addr_q;
   logic              dirty_q;
   logic              busy_q;
   logic              done_q;
   logic              served_last_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              w_rise;
   logic              w_fall;
   logic              w_in_range;
   logic [7:0]        w_rd_byte;

   assign w_rise     = ioctl_upload & ~upload_q;
   assign w_fall     = ~ioctl_upload & upload_q;
   assign w_in_range = (ioctl_addr < 25'(DEPTH));
   assign w_rd_byte  = (PAD_BYTE << DATA_W) | 8'(nv_q);

`ifdef NVRAM_UPLOAD_CSUM_EN
   logic       w_is_csum;
   logic [7:0] w_csum;

   assign w_is_csum = (ioctl_addr == 25'(DEPTH));

   nv_csum_acc u_csum (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .clr_i   (w_rise),
      .add_i   (state_q == ST_RESP),
      .byte_i  (din_q),
      .sum_o   (w_csum)
   );
`endif

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         upload_q      <= 1'b0;
         din_q         <= PAD_BYTE;
         wait_q        <= 1'b0;
         req_q         <= 1'b0;
         addr_q        <= '0;
         dirty_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         served_last_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         upload_q <= ioctl_upload;
         done_q   <= 1'b0;

         // CPU write beats the end-of-session clear
         if (cpu_nv_we) begin
            dirty_q <= 1'b1;
         end else if (w_fall && served_last_q) begin
            dirty_q <= 1'b0;
         end

         if (w_rise) begin
            served_last_q <= 1'b0;
         end

         if (w_fall) begin
            done_q  <= served_last_q;
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            wait_q  <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (ioctl_rd && ioctl_upload) begin
                     if (w_in_range) begin
                        addr_q  <= ioctl_addr[ADDR_W-1:0];
                        state_q <= ST_ARB;
                        wait_q  <= 1'b1;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
`ifdef NVRAM_UPLOAD_CSUM_EN
                     end else if (w_is_csum) begin
                        din_q         <= ~w_csum;
                        served_last_q <= 1'b1;
`endif
                     end else begin
                        din_q <= PAD_BYTE;
                     end
                  end
               end
               ST_ARB: begin
                  if (nv_gnt) begin
                     state_q <= ST_LAT;
                     cnt_q   <= LAT_LOAD;
                  end else if (cnt_q == TMO_LAST) begin
                     state_q <= ST_RESP;
                     req_q   <= 1'b0;
                     wait_q  <= 1'b0;
                     din_q   <= PAD_BYTE;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               ST_LAT: begin
                  if (cnt_q == '0) begin
                     state_q <= ST_RESP;
                     req_q   <= 1'b0;
                     wait_q  <= 1'b0;
                     din_q   <= w_rd_byte;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
               ST_RESP: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
`ifndef NVRAM_UPLOAD_CSUM_EN
                  if (addr_q == ADDR_W'(DEPTH - 1)) begin
                     served_last_q <= 1'b1;
                  end
`endif
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign ioctl_din   = din_q;
   assign ioctl_wait  = wait_q;
   assign nv_req      = req_q;
   assign nv_addr     = addr_q;
   assign nv_dirty    = dirty_q;
   assign upload_busy = busy_q;
   assign upload_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_nvram_upload_ctrl.sv
// ============================================================================
// Module   : tb_nvram_upload_ctrl
// Brief    : Self-checking bench for nvram_upload_ctrl (both checksum builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nvram_upload_ctrl;
   import joust2_nv_pkg::*;

   localparam int ADDR_W = NV_ADDR_W;
   localparam int DEPTH  = NV_DEPTH;
   localparam int TMO    = 64;
   localparam int NEVER  = 1000000;
`ifdef NVRAM_UPLOAD_CSUM_EN
   localparam bit CSUM      = 1'b1;
   localparam int LAST_ADDR = DEPTH;
`else
   localparam bit CSUM      = 1'b0;
   localparam int LAST_ADDR = DEPTH - 1;
`endif

   logic              clk_sys      = 1'b0;
   logic              reset_n      = 1'b0;
   logic              ioctl_upload = 1'b0;
   logic              ioctl_rd     = 1'b0;
   logic [24:0]       ioctl_addr   = '0;
   logic              cpu_nv_we    = 1'b0;
   logic [3:0]        nv_q         = '0;
   logic [7:0]        ioctl_din;
   logic              ioctl_wait;
   logic              nv_req;
   logic [ADDR_W-1:0] nv_addr;
   logic              nv_gnt;
   logic              nv_dirty;
   logic              upload_busy;
   logic              upload_done;

   nvram_upload_ctrl dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .ioctl_upload (ioctl_upload),
      .ioctl_rd     (ioctl_rd),
      .ioctl_addr   (ioctl_addr),
      .ioctl_din    (ioctl_din),
      .ioctl_wait   (ioctl_wait),
      .nv_req       (nv_req),
      .nv_addr      (nv_addr),
      .nv_gnt       (nv_gnt),
      .nv_q         (nv_q),
      .cpu_nv_we    (cpu_nv_we),
      .nv_dirty     (nv_dirty),
      .upload_busy  (upload_busy),
      .upload_done  (upload_done)
   );

   always #5 clk_sys = ~clk_sys;

   // CMOS port model: one grant per request, data valid for exactly one cycle
   logic [3:0] mem [DEPTH];
   int         age       = 0;
   bit         taken     = 1'b0;
   bit         rbit      = 1'b0;
   bit         gnt_rand  = 1'b0;
   int         gnt_delay = 0;

   assign nv_gnt = nv_req && !taken && (gnt_rand ? rbit : (age >= gnt_delay));

   always @(posedge clk_sys) begin
      rbit <= ($urandom_range(3) != 0);
      if (!nv_req) begin
         age   <= 0;
         taken <= 1'b0;
      end else begin
         age <= age + 1;
         if (nv_gnt) taken <= 1'b1;
      end
      nv_q <= nv_gnt ? mem[nv_addr] : 4'($urandom);
   end

   // Session-level reference model
   int         checks   = 0;
   int         failures = 0;
   bit         served_m = 1'b0;
   bit         dirty_m  = 1'b0;
   logic [7:0] csum_m   = 8'h00;

   typedef struct {
      int         addr;
      logic [3:0] nib;
      int         delay;
      logic [7:0] exp_din;
      int         exp_wait;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int a);
      if (a < DEPTH) return 8'hF0 | {4'h0, mem[a]};
      if (CSUM && a == DEPTH) return ~csum_m;
      return 8'hFF;
   endfunction

   function automatic void model_serve(input int a, input logic [7:0] b);
      if (a < DEPTH) csum_m = csum_m + b;
      if (a == LAST_ADDR) served_m = 1'b1;
   endfunction

   // Issue one read; returns din once wait drops, wait-cycle and req-cycle counts
   task automatic do_read(input int a, output logic [7:0] din, output int nwait,
                          output int nreq, output bit busy1);
      bit moved;
      moved      = 1'b0;
      ioctl_addr = 25'(a);
      ioctl_rd   = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      busy1    = upload_busy;
      nwait    = 0;
      nreq     = 0;
      while (ioctl_wait && nwait < 300) begin
         nwait++;
         if (nv_req) begin
            nreq++;
            if (nv_addr !== ADDR_W'(a)) moved = 1'b1;
         end
         tick();
      end
      if (nwait >= 300) begin
         checks++;
         failures++;
         $display("FAIL read_timeout: wait still high after %0d cycles, addr %0d", nwait, a);
      end
      if (nreq > 0) check("nv_addr_stable", moved, 0);
      din = ioctl_din;
      tick();
   endtask

   task automatic start_session();
      ioctl_upload = 1'b1;
      csum_m       = 8'h00;
      served_m     = 1'b0;
      tick();
   endtask

   task automatic pulse_we();
      cpu_nv_we = 1'b1;
      tick();
      cpu_nv_we = 1'b0;
      dirty_m   = 1'b1;
      check("dirty_set", nv_dirty, 1);
   endtask

   task automatic end_session(input bit we_same_cycle);
      ioctl_upload = 1'b0;
      cpu_nv_we    = we_same_cycle;
      tick();
      cpu_nv_we = 1'b0;
      if (we_same_cycle) dirty_m = 1'b1;
      else if (served_m) dirty_m = 1'b0;
      check("done_pulse", upload_done, served_m);
      check("dirty_after_end", nv_dirty, dirty_m);
      tick();
      check("done_one_cycle", upload_done, 0);
   endtask

   task automatic upload_all(input bit check_each);
      logic [7:0] d;
      int nw, nr;
      bit b1;
      for (int a = 0; a < DEPTH; a++) begin
         if (check_each && $urandom_range(15) == 0) begin
            int oor;
            oor = DEPTH + 1 + int'($urandom_range(33000000));
            do_read(oor, d, nw, nr, b1);
            check("rand_oor_din", d, 8'hFF);
         end
         do_read(a, d, nw, nr, b1);
         if (check_each) check("rand_din", d, exp_byte(a));
         model_serve(a, exp_byte(a));
      end
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] din_before;
      int nw, nr;
      bit b1;

      for (int i = 0; i < DEPTH; i++) mem[i] = 4'($urandom);

      vecs[0] = '{5,    4'hA, 0,     8'hFA, 2};
      vecs[1] = '{0,    4'h3, 0,     8'hF3, 2};
      vecs[2] = '{1023, 4'h7, 5,     8'hF7, 7};
      vecs[3] = '{1500, 4'h0, 0,     8'hFF, 0};
      vecs[4] = '{33,   4'h1, 0,     8'hF1, 2};
      vecs[5] = '{42,   4'hC, NEVER, 8'hFF, TMO};
      vecs[6] = '{33554431, 4'h0, 0, 8'hFF, 0};
      vecs[7] = '{512,  4'h0, 2,     8'hF0, 4};

      // Reset, with a read strobe held during reset
      ioctl_upload = 1'b1;
      ioctl_rd     = 1'b1;
      ioctl_addr   = 25'd5;
      tick();
      tick();
      check("rst_din", ioctl_din, 8'hFF);
      check("rst_wait", ioctl_wait, 0);
      check("rst_req", nv_req, 0);
      check("rst_dirty", nv_dirty, 0);
      check("rst_busy", upload_busy, 0);
      check("rst_done", upload_done, 0);
      ioctl_rd     = 1'b0;
      ioctl_upload = 1'b0;
      reset_n      = 1'b1;
      tick();
      tick();
      check("post_rst_req", nv_req, 0);
      check("post_rst_wait", ioctl_wait, 0);

      // Read with upload low is ignored
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'd5;
      tick();
      ioctl_rd = 1'b0;
      check("noupl_wait", ioctl_wait, 0);
      check("noupl_req", nv_req, 0);
      check("noupl_busy", upload_busy, 0);

      // Session A: directed vector table
      start_session();
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].addr < DEPTH) mem[vecs[i].addr] = vecs[i].nib;
         gnt_delay = vecs[i].delay;
         do_read(vecs[i].addr, d, nw, nr, b1);
         check("vec_din", d, vecs[i].exp_din);
         check("vec_wait_cycles", nw, vecs[i].exp_wait);
         check("vec_req_cycles", nr, vecs[i].exp_wait);
         check("vec_busy_start", b1, vecs[i].exp_wait > 0);
         check("vec_idle_after", upload_busy, 0);
         model_serve(vecs[i].addr, vecs[i].exp_din);
      end
      gnt_delay = 0;
`ifndef NVRAM_UPLOAD_CSUM_EN
      do_read(DEPTH, d, nw, nr, b1);
      check("depth_oor_din", d, 8'hFF);
      check("depth_oor_wait", nw, 0);
`endif
      pulse_we();
      end_session(1'b0);

      // Session B: randomized full upload against the model
      for (int i = 0; i < DEPTH; i++) mem[i] = 4'($urandom);
      pulse_we();
      gnt_rand = 1'b1;
      start_session();
      upload_all(1'b1);
`ifdef NVRAM_UPLOAD_CSUM_EN
      do_read(DEPTH, d, nw, nr, b1);
      check("rand_csum", d, exp_byte(DEPTH));
      check("rand_csum_wait", nw, 0);
      model_serve(DEPTH, d);
`endif
      end_session(1'b0);
      gnt_rand = 1'b0;

      // Session C: CPU write coincident with the end-of-session clear
      start_session();
      do_read(LAST_ADDR, d, nw, nr, b1);
      check("last_din", d, exp_byte(LAST_ADDR));
      model_serve(LAST_ADDR, d);
      end_session(1'b1);

      // Session D: abort while arbitrating
      start_session();
      gnt_delay  = NEVER;
      din_before = ioctl_din;
      ioctl_addr = 25'd7;
      ioctl_rd   = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      check("abort_req_arb", nv_req, 1);
      check("abort_wait_arb", ioctl_wait, 1);
      tick();
      tick();
      ioctl_upload = 1'b0;
      tick();
      check("abort_req", nv_req, 0);
      check("abort_wait", ioctl_wait, 0);
      check("abort_busy", upload_busy, 0);
      check("abort_done", upload_done, 0);
      check("abort_din", ioctl_din, din_before);
      tick();
      check("abort_done_later", upload_done, 0);
      gnt_delay = 0;

`ifdef NVRAM_UPLOAD_CSUM_EN
      // Checksum of an all-zero CMOS; done needs the checksum read
      for (int i = 0; i < DEPTH; i++) mem[i] = 4'h0;
      start_session();
      upload_all(1'b0);
      end_session(1'b0);
      start_session();
      upload_all(1'b0);
      do_read(DEPTH, d, nw, nr, b1);
      check("csum_zero", d, 8'hFF);
      check("csum_zero_wait", nw, 0);
      model_serve(DEPTH, d);
      end_session(1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
